// File: rtl/systolic_array.sv
`default_nettype none
// systolic_array: output-stationary NUM_ROW x NUM_COL MAC array with internal operand skew.
// Optional build macro SYSTOLIC_SIGNED_EN selects two's-complement arithmetic.
module systolic_array #(
    parameter int IN_WORD_SIZE  = 8,
    parameter int OUT_WORD_SIZE = 24,
    parameter int NUM_ROW       = 8,
    parameter int NUM_COL       = 8,
    parameter int INNER_DIM     = NUM_COL
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [IN_WORD_SIZE*NUM_ROW-1:0]                 left_inputs,
    input  logic [IN_WORD_SIZE*NUM_COL-1:0]                 top_inputs,
    output logic                                            compute_done,
    output logic [OUT_WORD_SIZE-1:0]                        cycles_count,
    output logic [0:OUT_WORD_SIZE*NUM_ROW*NUM_COL-1]        pe_register_vals
);
    localparam int W  = IN_WORD_SIZE;
    localparam int OW = OUT_WORD_SIZE;
    localparam int PW = 2 * IN_WORD_SIZE;
    localparam logic [OW-1:0] DONE_AT = OW'(INNER_DIM + NUM_ROW + NUM_COL + 2);

    // Operand presented to PE(r,c) this cycle.
    logic [W-1:0] a_op [NUM_ROW][NUM_COL];
    logic [W-1:0] b_op [NUM_ROW][NUM_COL];
    logic         run;

    assign run = !compute_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_count <= '0;
            compute_done <= 1'b0;
        end else if (run) begin
            cycles_count <= cycles_count + 1'b1;
            if (cycles_count + 1'b1 == DONE_AT)
                compute_done <= 1'b1;
        end
    end

    // Row r: input register plus r delay stages.
    for (genvar r = 0; r < NUM_ROW; r++) begin : g_left_skew
        logic [W-1:0] dly [0:r];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) dly[j] <= '0;
            end else if (run) begin
                dly[0] <= left_inputs[(r+1)*W-1 -: W];
                for (int j = 1; j <= r; j++) dly[j] <= dly[j-1];
            end
        end
        assign a_op[r][0] = dly[r];
    end

    for (genvar c = 0; c < NUM_COL; c++) begin : g_top_skew
        logic [W-1:0] dly [0:c];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= c; j++) dly[j] <= '0;
            end else if (run) begin
                dly[0] <= top_inputs[(c+1)*W-1 -: W];
                for (int j = 1; j <= c; j++) dly[j] <= dly[j-1];
            end
        end
        assign b_op[0][c] = dly[c];
    end

    for (genvar r = 0; r < NUM_ROW; r++) begin : g_pe_row
        for (genvar c = 0; c < NUM_COL; c++) begin : g_pe_col
            logic [OW-1:0] acc;
            logic [OW-1:0] prod_ext;
`ifdef SYSTOLIC_SIGNED_EN
            logic signed [PW-1:0] prod;
            assign prod     = PW'($signed(a_op[r][c])) * PW'($signed(b_op[r][c]));
            assign prod_ext = OW'(prod);
`else
            logic [PW-1:0] prod;
            assign prod     = PW'(a_op[r][c]) * PW'(b_op[r][c]);
            assign prod_ext = OW'(prod);
`endif
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    acc <= '0;
                else if (run)
                    acc <= acc + prod_ext;
            end

            // PE(0,0) lands at the MSB end of the ascending vector.
            assign pe_register_vals[(r*NUM_COL+c)*OW +: OW] = acc;

            if (c < NUM_COL - 1) begin : g_a_fwd
                logic [W-1:0] a_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        a_q <= '0;
                    else if (run)
                        a_q <= a_op[r][c];
                end
                assign a_op[r][c+1] = a_q;
            end

            if (r < NUM_ROW - 1) begin : g_b_fwd
                logic [W-1:0] b_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        b_q <= '0;
                    else if (run)
                        b_q <= b_op[r][c];
                end
                assign b_op[r+1][c] = b_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_systolic_array.sv
`default_nettype none
// tb_systolic_array: randomized and directed matrix-product checks against a plain-arithmetic model.
module tb_systolic_array;
    localparam int IW = 8;
    localparam int OW = 24;
    localparam int R  = 8;
    localparam int C  = 8;
    localparam int K  = 8;
    localparam int DONE_AT = K + R + C + 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [IW*R-1:0]        left_inputs = '0;
    logic [IW*C-1:0]        top_inputs = '0;
    logic                   compute_done;
    logic [OW-1:0]          cycles_count;
    logic [0:OW*R*C-1]      pe_vals;

    int total = 0;
    int bad   = 0;

    logic [IW-1:0] mat_a [R][K];
    logic [IW-1:0] mat_b [K][C];
    logic [OW-1:0] ref_c [R][C];

    systolic_array #(
        .IN_WORD_SIZE (IW),
        .OUT_WORD_SIZE(OW),
        .NUM_ROW      (R),
        .NUM_COL      (C),
        .INNER_DIM    (K)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .left_inputs     (left_inputs),
        .top_inputs      (top_inputs),
        .compute_done    (compute_done),
        .cycles_count    (cycles_count),
        .pe_register_vals(pe_vals)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] pe(input int r, input int c);
        return pe_vals[(r*C+c)*OW +: OW];
    endfunction

    function automatic int opval(input logic [IW-1:0] x);
`ifdef SYSTOLIC_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < R; i++)
            for (int k = 0; k < K; k++)
                case (mode)
                    0: mat_a[i][k] = 8'h01;
                    1: mat_a[i][k] = (i == k) ? 8'h01 : 8'h00;
                    2: mat_a[i][k] = 8'hFF;
                    default: mat_a[i][k] = IW'($urandom);
                endcase
        for (int k = 0; k < K; k++)
            for (int j = 0; j < C; j++)
                case (mode)
                    0: mat_b[k][j] = 8'h01;
                    1: mat_b[k][j] = IW'(8*k + j);
                    2: mat_b[k][j] = 8'hFF;
                    default: mat_b[k][j] = IW'($urandom);
                endcase
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                int sum = 0;
                for (int k = 0; k < K; k++)
                    sum += opval(mat_a[i][k]) * opval(mat_b[k][j]);
                ref_c[i][j] = OW'(sum);
            end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        left_inputs = '0;
        top_inputs = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_step(input int k);
        for (int i = 0; i < R; i++) left_inputs[i*IW +: IW] = mat_a[i][k];
        for (int j = 0; j < C; j++) top_inputs[j*IW +: IW] = mat_b[k][j];
    endtask

    task automatic check_pes(input string tag);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                check_val($sformatf("%s_pe%0d_%0d", tag, i, j), 32'(pe(i, j)), 32'(ref_c[i][j]));
    endtask

    // Called at the negedge right after reset release; step 0 is captured on the next edge.
    task automatic stream_and_check(input string tag);
        int edges = 0;
        for (int k = 0; k < K; k++) begin
            drive_step(k);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        left_inputs = '0;
        top_inputs = '0;
        while (!compute_done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_val({tag, "_done"}, 32'(compute_done), 32'd1);
        check_val({tag, "_edges"}, 32'(edges), 32'(DONE_AT));
        check_val({tag, "_count"}, 32'(cycles_count), 32'(DONE_AT));
        check_pes(tag);
    endtask

    initial begin
        // Reset state before any post-release edge.
        do_reset();
        check_val("rst_done", 32'(compute_done), 32'd0);
        check_val("rst_count", 32'(cycles_count), 32'd0);
        check_val("rst_pe_any", 32'(|pe_vals), 32'd0);

        fill(0);
        stream_and_check("ones");
        check_val("ones_pe00_const", 32'(pe(0, 0)),
`ifdef SYSTOLIC_SIGNED_EN
                  32'h000008);
`else
                  32'h000008);
`endif

        fill(1);
        do_reset();
        stream_and_check("ident");
        check_val("ident_pe77", 32'(pe(7, 7)), 32'h00003F);

        fill(2);
        do_reset();
        stream_and_check("maxop");
`ifdef SYSTOLIC_SIGNED_EN
        check_val("maxop_pe34", 32'(pe(3, 4)), 32'h000008);
`else
        check_val("maxop_pe34", 32'(pe(3, 4)), 32'h07F008);
`endif

        // Post-done hold: noise on inputs must not disturb frozen state.
        left_inputs = {R{8'h55}};
        top_inputs = {C{8'h55}};
        repeat (20) @(negedge clk);
        check_val("hold_done", 32'(compute_done), 32'd1);
        check_val("hold_count", 32'(cycles_count), 32'(DONE_AT));
        check_pes("hold");

        for (int t = 0; t < 3; t++) begin
            fill(3);
            do_reset();
            stream_and_check($sformatf("rand%0d", t));
        end

        // Mid-run abort: asynchronous reset between edges, then restream.
        fill(3);
        do_reset();
        for (int k = 0; k < K; k++) begin
            drive_step(k);
            @(negedge clk);
        end
        left_inputs = '0;
        top_inputs = '0;
        repeat (2) @(negedge clk);
        check_val("abort_pre_count", 32'(cycles_count), 32'd10);
        #2 rst = 1'b1;
        #1;
        check_val("abort_async_count", 32'(cycles_count), 32'd0);
        check_val("abort_async_done", 32'(compute_done), 32'd0);
        check_val("abort_async_pe_any", 32'(|pe_vals), 32'd0);
        fill(0);
        do_reset();
        stream_and_check("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
